midi_uart_rx: RTL
=================

# midi_uart_rx

MIDI serial receiver (31250 baud, 8N1) clocked from the system clock. It consumes the 8x-oversample baud strobe produced by the comms clock stage and recovers bytes from the raw MIDI input line. Each frame is delivered as a parallel byte with a one-cycle valid strobe to the MIDI message parser downstream. It detects false starts, rejects single-sample noise by majority vote, and flags framing errors.

## Interface
- `OVERSAMPLE`, 8, ticks per bit; fixed at 8, phase counter is 3 bits.
- `DATA_BITS`, 8, data bits per frame, LSB first.
- `clk`  in  1  system clock (12 MHz); all state on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `sample_tick`  in  1  one-`clk`-wide strobe at 8x baud (250 kHz, i.e. every 48 `clk`); may be held high continuously in test.
- `rx`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `data`  out  8  last correctly framed byte; holds until the next good frame.
- `data_valid`  out  1  one-`clk` pulse, `data` updated the same cycle.
- `framing_error`  out  1  one-`clk` pulse, stop bit sampled low.
- `busy`  out  1  high whenever state != IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer, both flops reset to 1, giving `rx_s`.
- State and phase counter (0..7) advance only on `clk` cycles with `sample_tick`=1.
- Majority vote `maj` covers `rx_s` captured at phases 3, 4 and 5 of the current bit. It is evaluated at phase 5 using the phase-5 sample directly.
- `armed` flag:
  - Cleared by reset and by a framing error.
  - Set on any tick in IDLE with `rx_s`=1.
  - IDLE ignores a low line while `armed`=0, so no false frame is taken from a held-low line or a break.
- IDLE: tick with `rx_s`=0 and `armed`=1 -> START, phase=0.
- START:
  - At phase 5, `maj`=1 -> IDLE (false start, no output).
  - At phase 7 -> DATA, phase=0, bit_idx=0.
- DATA:
  - At phase 5, shift `maj` into the MSB of an 8-bit shift register (shift right).
  - At phase 7, bit_idx==7 -> STOP, phase=0; otherwise bit_idx+1, phase=0.
- STOP, acting at phase 5:
  - `maj`=1: `data`<=shift register, `data_valid` pulse.
  - `maj`=0: `framing_error` pulse, `data` unchanged, `armed`<=0.
  - Either way -> IDLE at phase 5, so the next start edge can be caught 3 ticks early (resync margin).
- Phase counter wraps 7->0 only at bit boundaries. Phase is never reset on a tick mid-bit.
- `data_valid` and `framing_error` are registered pulses, cleared every `clk` that does not set them. They are never high together.

## Timing
- Reset values: `data`=0x00, `data_valid`=0, `framing_error`=0, `busy`=0, state=IDLE, `armed`=0, sync flops=1.
- Reset asserted mid-frame aborts immediately: no partial byte, no pulse.
- Input latency: 2 `clk` synchronizer, then start is detected on the first tick seeing `rx_s`=0 (tick T0, START phase 0).
- The STOP phase-5 decision falls on tick T0+77. `data_valid`/`framing_error` go high the `clk` after that tick and stay high exactly 1 `clk`.
- `busy` rises the `clk` after T0 and falls with the output pulse, or the `clk` after T0+5 on a false start.
- Back-to-back frames with zero idle are received without loss. The start bit of frame n+1 begins 3 ticks after the STOP decision of frame n.
- `sample_tick` at every `clk` is legal: behaviour is identical in tick counts.

## Test plan
- Ticks every 48 `clk`, send 0x90 after a long idle high -> `data`=0x90, `data_valid` high for 1 `clk` right after tick T0+77, `busy` low afterwards.
- Three frames 0x90, 0x3C, 0x7F with no idle between them -> three `data_valid` pulses carrying the values in order, no `framing_error`.
- Line low for 2 ticks only (phases 0-1) -> no pulses; `busy` high for 6 ticks then low; a following 0x45 frame is received correctly.
- 0xA5 with stop bit held low -> `framing_error` pulse, `data` keeps the previous byte. While the line stays low, no new frame starts. After the line returns high, a 0x12 frame is received.
- Assert `rst` mid-data of 0xFF with the line low, release while still low -> all outputs at reset values, no reception until the line goes high. Then a 0x55 frame gives `data`=0x55.
- Send 0x00 with a single-tick glitch high at phase 4 of bit 3 -> `data`=0x00 (majority rejects it). Glitch at phases 4 and 5 -> `data`=0x08.

Source files
------------

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: MIDI serial receiver (31250 baud, 8N1) running in the system
// clock domain and paced by an 8x-oversample baud strobe.
//
// Ports:
//   clk           system clock; all state changes on its rising edge
//   rst           asynchronous, active-high reset
//   sample_tick   one-clk strobe at 8x baud (may be held high continuously)
//   rx            raw serial line, idle high, asynchronous to clk
//   data          last correctly framed byte, held until the next good frame
//   data_valid    one-clk pulse, data updated in the same cycle
//   framing_error one-clk pulse, stop bit sampled low
//   busy          high whenever a frame is in progress
//
// Each bit is eight ticks long (phases 0..7). The line level is decided by a
// majority vote over the samples taken at phases 3, 4 and 5, evaluated at
// phase 5 using the phase-5 sample directly.
module midi_uart_rx #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 busy
);

  localparam logic [2:0] PH_LAST  = 3'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] PH_S3    = 3'd3;
  localparam logic [2:0] PH_S4    = 3'd4;
  localparam logic [2:0] PH_VOTE  = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Two-of-three majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

  logic                 rx_meta;
  logic                 rx_s;
  state_t               state, state_next;
  logic [2:0]           phase, phase_next;
  logic [2:0]           bit_idx, bit_idx_next;
  logic                 samp3, samp3_next;
  logic                 samp4, samp4_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 armed, armed_next;
  logic [DATA_BITS-1:0] data_next;
  logic                 data_valid_next;
  logic                 framing_error_next;
  logic                 busy_next;
  logic                 maj;

  assign maj = maj3(samp3, samp4, rx_s);

  // Two-flop synchronizer for the asynchronous serial line (resets to idle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Next-state, datapath and output-pulse logic; everything except the
  // pulses only moves on a sample tick.
  always_comb begin
    state_next         = state;
    phase_next         = phase;
    bit_idx_next       = bit_idx;
    samp3_next         = samp3;
    samp4_next         = samp4;
    shift_next         = shift;
    armed_next         = armed;
    data_next          = data;
    data_valid_next    = 1'b0;
    framing_error_next = 1'b0;

    if (sample_tick) begin
      if (phase == PH_S3) begin
        samp3_next = rx_s;
      end else begin
        samp3_next = samp3;
      end
      if (phase == PH_S4) begin
        samp4_next = rx_s;
      end else begin
        samp4_next = samp4;
      end

      case (state)
        IDLE: begin
          phase_next = 3'd0;
          if (rx_s) begin
            armed_next = 1'b1;
          end else if (armed) begin
            // The detecting tick is phase 0 of the start bit, so the
            // next tick is already phase 1.
            state_next = START;
            phase_next = 3'd1;
          end else begin
            state_next = IDLE;
          end
        end
        START: begin
          if ((phase == PH_VOTE) && maj) begin
            state_next = IDLE;
            phase_next = 3'd0;
          end else if (phase == PH_LAST) begin
            state_next   = DATA;
            phase_next   = 3'd0;
            bit_idx_next = 3'd0;
          end else begin
            phase_next = phase + 3'd1;
          end
        end
        DATA: begin
          phase_next = phase + 3'd1;
          if (phase == PH_VOTE) begin
            shift_next = {maj, shift[DATA_BITS-1:1]};
          end else begin
            shift_next = shift;
          end
          if (phase == PH_LAST) begin
            if (bit_idx == BIT_LAST) begin
              state_next = STOP;
            end else begin
              bit_idx_next = bit_idx + 3'd1;
            end
          end else begin
            bit_idx_next = bit_idx;
          end
        end
        STOP: begin
          if (phase == PH_VOTE) begin
            // Leave early so the next start edge is seen with margin.
            state_next = IDLE;
            phase_next = 3'd0;
            if (maj) begin
              data_next       = shift;
              data_valid_next = 1'b1;
            end else begin
              framing_error_next = 1'b1;
              armed_next         = 1'b0;
            end
          end else begin
            phase_next = phase + 3'd1;
          end
        end
        default: begin
          state_next = IDLE;
          phase_next = 3'd0;
        end
      endcase
    end else begin
      state_next = state;
    end

    busy_next = (state_next != IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      phase         <= 3'd0;
      bit_idx       <= 3'd0;
      samp3         <= 1'b1;
      samp4         <= 1'b1;
      shift         <= '0;
      armed         <= 1'b0;
      data          <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_next;
      phase         <= phase_next;
      bit_idx       <= bit_idx_next;
      samp3         <= samp3_next;
      samp4         <= samp4_next;
      shift         <= shift_next;
      armed         <= armed_next;
      data          <= data_next;
      data_valid    <= data_valid_next;
      framing_error <= framing_error_next;
      busy          <= busy_next;
    end
  end

endmodule
